regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file; successor to the single-write/2-read RV32 file.
//  Adds N read ports, 2 write ports with fixed priority, and a hardware clear sequencer on reset.
//  Sits in the datapath between decode (addresses) and ALU/writeback (operands, results).
// PARAMETERS
//  XLEN      32  data width in bits
//  DEPTH     32  number of entries (power of 2, >=2)
//  NUM_RD     2  number of read ports (1..4)
//  ZERO_REG   1  1: entry 0 reads 0 and ignores writes; 0: entry 0 is an ordinary register
// PORTS
//  clk     in   1                clock, all state on posedge
//  rst     in   1                synchronous active-high reset; starts clear sequence
//  ra      in   NUM_RD*AW        read addresses, port i = ra[i*AW +: AW], AW=$clog2(DEPTH)
//  rd      out  NUM_RD*XLEN      read data, port i = rd[i*XLEN +: XLEN]
//  wa0     in   AW               write port 0 address
//  wd0     in   XLEN             write port 0 data
//  we0     in   1                write port 0 enable
//  wa1     in   AW               write port 1 address
//  wd1     in   XLEN             write port 1 data
//  we1     in   1                write port 1 enable (priority over port 0)
//  ready   out  1                1 = clear done, writes accepted, reads valid
// BEHAVIOUR
//  - Reads are combinational from the array; no read latency.
//  - Writes commit on posedge clk when weN=1 and ready=1; visible on rd the next cycle.
//  - wa0==wa1 with both enabled: wd1 written; wd0 dropped.
//  - ZERO_REG=1: address 0 reads 0; writes to address 0 are discarded on both ports.
//  - Clear FSM, two states: CLEAR, RUN.
//    - rst=1 (any state, any cycle): next state CLEAR, clr_idx<=0, ready<=0.
//    - CLEAR: entry[clr_idx]<=0 each cycle; clr_idx increments.
//      At clr_idx==DEPTH-1, write the last entry and go to RUN.
//    - RUN: ready=1; normal operation; stays until rst.
//    - Clear takes exactly DEPTH cycles after rst deasserts; ready rises in cycle DEPTH.
//    - rst reasserted mid-clear restarts at clr_idx=0.
//  - While ready=0: all rd ports read 0; we0/we1 are ignored (no write, no error).
//  - Reset values: ready=0, state=CLEAR, clr_idx=0. rd=0 from the first cycle after rst.
//  - clr_idx width AW; never wraps because it exits at DEPTH-1.
// CONFIGURATION
//  RF_BYPASS_EN defined:
//    - If a read address equals an enabled write address in the same cycle (ready=1,
//      address not a discarded zero-reg write), rd returns that write data combinationally.
//    - Port 1 data wins if both ports match.
//  RF_BYPASS_EN undefined:
//    - rd returns the pre-write array value; the new value appears the next cycle.
// STRUCTURE
//  Package rf_pkg:
//    - rf_state_t enum {RF_CLEAR, RF_RUN}
//    - default XLEN/DEPTH localparams
//    - clog2 helper function
//  Sub-module rf_clear_seq (clk, rst, busy, clr_we, clr_idx): FSM + index counter.
//    - The top muxes clr_we/clr_idx/0 onto the array write path while busy.
//  Top holds the array, the write-priority mux, the read mux generate loop, and the bypass.
// TESTING
//  1. rst 1 cycle, then idle -> ready=0 for 32 cycles, ready=1 in cycle 32; all 32 entries read 0.
//  2. Write x5=0xDEADBEEF via port0 -> next cycle ra[0]=5 gives 0xDEADBEEF;
//     same-cycle read returns the old value without RF_BYPASS_EN, 0xDEADBEEF with it.
//  3. we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 -> x7 reads 0x22.
//  4. Write x0=0xFFFFFFFF with ZERO_REG=1 -> x0 reads 0; with ZERO_REG=0 -> x0 reads 0xFFFFFFFF.
//  5. Fill x1..x31, pulse rst at clear cycle 10, then again after ready -> clear restarts;
//     ready rises exactly 32 cycles after the last rst; all entries read 0.
//  6. Writes during ready=0 (wa0=3, wd0=0x55) -> x3 reads 0 after ready rises.
//     NUM_RD=4, DEPTH=16 build passes 1-4.

Source files
------------

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg: shared types and defaults for the multi-port register file.
//   rf_state_t  : clear-sequencer states (RF_CLEAR, RF_RUN)
//   RF_*_DEF    : default width / depth / read-port count
//   rf_clog2    : ceil(log2(value)); used to size address fields
// ---------------------------------------------------------------------------
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int RF_XLEN_DEF   = 32;
  localparam int RF_DEPTH_DEF  = 32;
  localparam int RF_NUM_RD_DEF = 2;

  function automatic int rf_clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if: operand/result bus of the register file.
//   ra    : NUM_RD packed read addresses, port i = ra[i*AW +: AW]
//   rd    : NUM_RD packed read data,      port i = rd[i*XLEN +: XLEN]
//   wa0/wd0/we0, wa1/wd1/we1 : two write ports, port 1 has priority
//   ready : clear sequence finished; writes accepted, reads valid
// Modports: master = decode/writeback side, slave = register file.
// ---------------------------------------------------------------------------
interface regfile_mp_if
  import rf_pkg::*;
#(
  parameter int XLEN   = RF_XLEN_DEF,
  parameter int DEPTH  = RF_DEPTH_DEF,
  parameter int NUM_RD = RF_NUM_RD_DEF
) ();

  localparam int AW = rf_clog2(DEPTH);

  logic [NUM_RD*AW-1:0]   ra;
  logic [NUM_RD*XLEN-1:0] rd;
  logic [AW-1:0]          wa0;
  logic [XLEN-1:0]        wd0;
  logic                   we0;
  logic [AW-1:0]          wa1;
  logic [XLEN-1:0]        wd1;
  logic                   we1;
  logic                   ready;

  modport master (
    output ra, wa0, wd0, we0, wa1, wd1, we1,
    input  rd, ready
  );

  modport slave (
    input  ra, wa0, wd0, we0, wa1, wd1, we1,
    output rd, ready
  );

endinterface

// File: rtl/rf_clear_seq.sv
// ---------------------------------------------------------------------------
// rf_clear_seq: walks every entry once after reset, zeroing it.
//   clk     : clock
//   rst     : synchronous active-high reset, (re)starts the walk at entry 0
//   busy    : 1 while the walk is in progress (register file not ready)
//   clr_we  : write strobe for the zeroing write
//   clr_idx : entry being zeroed this cycle
// The walk takes exactly DEPTH cycles after rst drops; busy falls on the
// edge that writes the last entry.
// ---------------------------------------------------------------------------
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH_DEF,
  parameter int AW    = rf_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rf_state_t     state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RF_CLEAR;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      RF_CLEAR: begin
        // Exit on the last entry instead of wrapping the index.
        if (idx_reg == LAST_IDX) state_next = RF_RUN;
        else                     idx_next   = idx_reg + 1'b1;
      end
      RF_RUN:  state_next = RF_RUN;
      default: state_next = RF_CLEAR;
    endcase
  end

  assign busy    = (state_reg == RF_CLEAR);
  assign clr_we  = busy;
  assign clr_idx = idx_reg;

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp: parametrised register file, NUM_RD combinational read ports,
// two write ports (port 1 wins on an address clash), hardware clear on reset.
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset, starts the clear sequence
//   bus  : regfile_mp_if.slave (ra/rd read ports, wa/wd/we write ports, ready)
// While ready=0 every read port returns 0 and writes are ignored.
// ZERO_REG=1 makes entry 0 a constant zero; writes to it are discarded.
// Build option: define RF_BYPASS_EN to forward same-cycle write data to a
// matching read port (port 1 data wins); otherwise reads see the old value.
// ---------------------------------------------------------------------------
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN     = RF_XLEN_DEF,
  parameter int DEPTH    = RF_DEPTH_DEF,
  parameter int NUM_RD   = RF_NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int AW = rf_clog2(DEPTH);

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_idx;
  logic          ready;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  assign ready     = ~busy;
  assign bus.ready = ready;

  // Effective write enables: gated by ready, and a write to a hard-wired
  // zero entry is treated as no write at all (also excludes it from bypass).
  logic w0_en, w1_en;
  assign w0_en = ready & bus.we0 & ~((ZERO_REG != 0) && (bus.wa0 == '0));
  assign w1_en = ready & bus.we1 & ~((ZERO_REG != 0) && (bus.wa1 == '0));

  logic [XLEN-1:0] entry_q [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign entry_q[gi] = '0;
      end else begin : g_reg
        logic [XLEN-1:0] q_reg;
        // Clear write first, then port 1 over port 0.
        always_ff @(posedge clk) begin
          if (clr_we && (clr_idx == AW'(gi))) begin
            q_reg <= '0;
          end else if (w1_en && (bus.wa1 == AW'(gi))) begin
            q_reg <= bus.wd1;
          end else if (w0_en && (bus.wa0 == AW'(gi))) begin
            q_reg <= bus.wd0;
          end
        end
        assign entry_q[gi] = q_reg;
      end
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      assign addr = bus.ra[gi*AW +: AW];
      always_comb begin
        data = entry_q[addr];
`ifdef RF_BYPASS_EN
        if (w1_en && (bus.wa1 == addr)) begin
          data = bus.wd1;
        end else if (w0_en && (bus.wa0 == addr)) begin
          data = bus.wd0;
        end
`endif
        if (!ready) data = '0;
      end
      assign bus.rd[gi*XLEN +: XLEN] = data;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp: directed bench for regfile_mp (XLEN=32, DEPTH=32, NUM_RD=2).
// A second instance with ZERO_REG=0 shares all inputs so entry-0 behaviour
// can be compared between the two configurations.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;

  localparam bit BYP =
`ifdef RF_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus   ();
  regfile_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus_z ();

  assign bus_z.ra  = bus.ra;
  assign bus_z.wa0 = bus.wa0;
  assign bus_z.wd0 = bus.wd0;
  assign bus_z.we0 = bus.we0;
  assign bus_z.wa1 = bus.wa1;
  assign bus_z.wd1 = bus.wd1;
  assign bus_z.we1 = bus.we1;

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(0)) dut_z (
    .clk (clk),
    .rst (rst),
    .bus (bus_z.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [31:0] byp(input logic [31:0] old_v, input logic [31:0] new_v);
    return BYP ? new_v : old_v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    bus.we0 = e0; bus.wa0 = a0; bus.wd0 = d0;
    bus.we1 = e1; bus.wa1 = a1; bus.wd1 = d1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
    bus.ra = {a1, a0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 0 after rst drops. Checks ready stays low and reads
  // are forced to 0 for DEPTH cycles, then ready is high in cycle DEPTH.
  // With drv set, writes to x3/x4 are attempted throughout the clear.
  task automatic clear_check(input string tag, input bit drv);
    for (int c = 0; c < DEPTH; c++) begin
      if (drv) drive(1'b1, 5'd3, 32'h55, 1'b1, 5'd4, 32'h66);
      set_ra(5'd31, 5'd3);
      @(negedge clk);
      chk($sformatf("%s ready low c%0d", tag, c), {31'b0, bus.ready}, 32'd0);
      chk($sformatf("%s rd0 zero c%0d", tag, c), bus.rd[31:0], 32'h0);
      next_cycle();
    end
    idle();
    @(negedge clk);
    chk($sformatf("%s ready high c%0d", tag, DEPTH), {31'b0, bus.ready}, 32'd1);
    $display("%s: clear sequence done", tag);
    next_cycle();
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a += 2) begin
      set_ra(5'(a), 5'(a + 1));
      @(negedge clk);
      chk($sformatf("%s x%0d", tag, a), bus.rd[31:0], 32'h0);
      chk($sformatf("%s x%0d", tag, a + 1), bus.rd[63:32], 32'h0);
      next_cycle();
    end
    $display("%s: all entries read", tag);
  endtask

  task automatic fill();
    for (int a = 1; a < DEPTH; a++) begin
      drive(1'b1, 5'(a), 32'h1000_0000 + 32'(a), 1'b0, 5'd0, 32'h0);
      next_cycle();
    end
    idle();
  endtask

  initial begin
    //                we0  wa0    wd0           we1  wa1    wd1           ra0    ra1    exp0                              exp1
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  byp(32'h0, 32'hDEADBEEF),         32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd7,  32'hDEADBEEF,                     32'h0};
    vecs[2]  = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  32'h22,       5'd7,  5'd5,  byp(32'h0, 32'h22),               32'hDEADBEEF};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'h22,                           32'h0};
    vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,                            32'h22};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,                            32'hDEADBEEF};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,                            32'h0};
    vecs[7]  = '{1'b1, 5'd10, 32'hCAFEF00D, 1'b1, 5'd9,  32'h12345678, 5'd9,  5'd10, byp(32'h0, 32'h12345678),         byp(32'h0, 32'hCAFEF00D)};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  5'd10, 32'h12345678,                     32'hCAFEF00D};
    vecs[9]  = '{1'b1, 5'd9,  32'hA5A5A5A5, 1'b1, 5'd10, 32'h5A5A5A5A, 5'd10, 5'd9,  byp(32'hCAFEF00D, 32'h5A5A5A5A),  byp(32'h12345678, 32'hA5A5A5A5)};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  5'd10, 32'hA5A5A5A5,                     32'h5A5A5A5A};
    vecs[11] = '{1'b0, 5'd10, 32'hBAD0BAD0, 1'b0, 5'd9,  32'hBAD1BAD1, 5'd9,  5'd10, 32'hA5A5A5A5,                     32'h5A5A5A5A};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd10, 5'd9,  32'h5A5A5A5A,                     32'hA5A5A5A5};
    vecs[13] = '{1'b1, 5'd7,  32'h77,       1'b1, 5'd8,  32'h88,       5'd8,  5'd7,  byp(32'h0, 32'h88),               byp(32'h22, 32'h77)};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd8,  32'h77,                           32'h88};

    idle();
    set_ra(5'd0, 5'd0);

    // Power-up: one reset cycle, then the full clear.
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_check("pwr", 1'b0);
    read_all_zero("pwr");

    // Table: writes, priority, zero register, bypass behaviour.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].we0, vecs[i].wa0, vecs[i].wd0, vecs[i].we1, vecs[i].wa1, vecs[i].wd1);
      set_ra(vecs[i].ra0, vecs[i].ra1);
      @(negedge clk);
      chk($sformatf("vec%0d rd0", i), bus.rd[31:0], vecs[i].exp0);
      chk($sformatf("vec%0d rd1", i), bus.rd[63:32], vecs[i].exp1);
      $display("vec %0d: ra0=%0d rd0=%h ra1=%0d rd1=%h", i, vecs[i].ra0, bus.rd[31:0],
               vecs[i].ra1, bus.rd[63:32]);
      next_cycle();
    end
    idle();

    // x0 after two all-ones writes: constant zero vs ordinary register.
    set_ra(5'd0, 5'd7);
    @(negedge clk);
    chk("zreg1 x0", bus.rd[31:0], 32'h0);
    chk("zreg0 x0", bus_z.rd[31:0], 32'hFFFFFFFF);
    chk("zreg0 x7", bus_z.rd[63:32], 32'h77);
    $display("zero-reg compare: x0=%h (ZERO_REG=1) x0=%h (ZERO_REG=0)", bus.rd[31:0], bus_z.rd[31:0]);
    next_cycle();

    // Fill, reset, reset again at clear cycle 10; writes attempted while not ready.
    fill();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 5'd3, 32'h55, 1'b1, 5'd4, 32'h66);
      set_ra(5'd31, 5'd3);
      @(negedge clk);
      chk($sformatf("part ready low c%0d", c), {31'b0, bus.ready}, 32'd0);
      chk($sformatf("part rd0 zero c%0d", c), bus.rd[31:0], 32'h0);
      next_cycle();
    end
    $display("partial clear: reasserting rst at clear cycle 10");
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    clear_check("midclr", 1'b1);
    read_all_zero("midclr");

    // Reset after ready: clear restarts from scratch.
    fill();
    set_ra(5'd31, 5'd1);
    @(negedge clk);
    chk("filled x31", bus.rd[31:0], 32'h1000_001F);
    chk("filled x1", bus.rd[63:32], 32'h1000_0001);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    clear_check("rerun", 1'b0);
    read_all_zero("rerun");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
